// File: rtl/io_pkg.sv
// Shared definitions for the programmed-I/O terminal: character width and FSM encodings.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package io_pkg;

  // Character width, shared with the controller and ALU for INPR/OUTR.
  localparam int DATA_W = 8;

  typedef enum logic {
    IN_IDLE = 1'b0,
    IN_FULL = 1'b1
  } in_state_e;

  typedef enum logic [1:0] {
    OUT_IDLE = 2'd0,
    OUT_CAPT = 2'd1,
    OUT_SEND = 2'd2
  } out_state_e;

endpackage

// File: rtl/io_terminal_if.sv
// Bundle of the CPU flag/register signals and the external rx/tx character streams.
// Latency: n/a (wiring only).
// Backpressure: rx_ready/tx_ready valid-ready pairs carried through unchanged.
interface io_terminal_if;

  // External input character stream
  logic                      rx_valid;
  logic [io_pkg::DATA_W-1:0] rx_data;
  logic                      rx_ready;

  // CPU-side INPR / FGI
  logic [io_pkg::DATA_W-1:0] inpr_data;
  logic                      fgi;
  logic                      fgi_clr;

  // CPU-side OUTR / FGO
  logic [io_pkg::DATA_W-1:0] outr_data;
  logic                      fgo;
  logic                      fgo_clr;

  // External output character stream
  logic                      tx_valid;
  logic [io_pkg::DATA_W-1:0] tx_data;
  logic                      tx_ready;

  // Interrupt and status
  logic                      ien;
  logic                      irq;
  logic                      out_overrun;

  // CPU/environment side
  modport master (
    output rx_valid, rx_data, fgi_clr, outr_data, fgo_clr, tx_ready, ien,
    input  rx_ready, inpr_data, fgi, fgo, tx_valid, tx_data, irq, out_overrun
  );

  // Device side (io_terminal)
  modport slave (
    input  rx_valid, rx_data, fgi_clr, outr_data, fgo_clr, tx_ready, ien,
    output rx_ready, inpr_data, fgi, fgo, tx_valid, tx_data, irq, out_overrun
  );

endinterface

// File: rtl/io_fifo.sv
// Small synchronous FIFO buffering input characters ahead of INPR.
// Latency: a pushed entry is visible on head the edge after the push.
// Backpressure: full blocks pushes, empty blocks pops; simultaneous push and pop keep the count.
module io_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             push_ok, pop_ok;

  assign full  = (cnt_q == CW'(DEPTH));
  assign empty = (cnt_q == '0);
  assign head  = mem_q[rd_ptr_q];

  // Guarded pointer/count update; pointers wrap naturally since DEPTH is a power of two.
  always_comb begin
    push_ok  = push & ~full;
    pop_ok   = pop & ~empty;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push_ok, pop_ok})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Pointer and count registers; reset empties the buffer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage needs no reset: entries are only read after being written.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_dat;
  end

endmodule

// File: rtl/io_terminal.sv
// Device end of the INPR/FGI and OUTR/FGO programmed-I/O handshake, plus the IEN-qualified interrupt.
// Latency: push into empty buffer -> fgi=1 in 2 edges; fgo_clr -> tx_valid in 2 edges.
// Backpressure: rx_ready drops when the input buffer is full; tx_data held until tx_ready.
module io_terminal
  import io_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  io_terminal_if.slave bus
);

  // Input path state
  in_state_e         in_state_q, in_state_d;
  logic              fgi_q, fgi_d;
  logic [DATA_W-1:0] inpr_q, inpr_d;
  logic              fifo_pop;
  logic              fifo_full, fifo_empty;
  logic [DATA_W-1:0] fifo_head;

  // Output path state
  out_state_e        out_state_q, out_state_d;
  logic              fgo_q, fgo_d;
  logic              tx_vld_q, tx_vld_d;
  logic [DATA_W-1:0] tx_dat_q, tx_dat_d;
  logic              ovr_q, ovr_d;

  logic              irq_q, irq_d;

  io_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_W)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (reset),
    .push     (bus.rx_valid & ~fifo_full),
    .push_dat (bus.rx_data),
    .pop      (fifo_pop),
    .head     (fifo_head),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  assign bus.rx_ready    = ~fifo_full;
  assign bus.inpr_data   = inpr_q;
  assign bus.fgi         = fgi_q;
  assign bus.fgo         = fgo_q;
  assign bus.tx_valid    = tx_vld_q;
  assign bus.tx_data     = tx_dat_q;
  assign bus.irq         = irq_q;
  assign bus.out_overrun = ovr_q;

  // Input FSM: move the buffer head into INPR whenever the CPU has consumed the previous character.
  always_comb begin
    in_state_d = in_state_q;
    fgi_d      = fgi_q;
    inpr_d     = inpr_q;
    fifo_pop   = 1'b0;
    case (in_state_q)
      IN_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop   = 1'b1;
          inpr_d     = fifo_head;
          fgi_d      = 1'b1;
          in_state_d = IN_FULL;
        end
      end
      IN_FULL: begin
        if (bus.fgi_clr) begin
          fgi_d      = 1'b0;
          in_state_d = IN_IDLE;
        end
      end
      default: begin
        in_state_d = IN_IDLE;
      end
    endcase
  end

  // Output FSM: capture OUTR the cycle after OUT, offer it to the sink, re-arm FGO on acceptance.
  // A clear arriving while FGO is already low is a CPU protocol error and only sets the sticky flag.
  always_comb begin
    out_state_d = out_state_q;
    fgo_d       = fgo_q;
    tx_vld_d    = tx_vld_q;
    tx_dat_d    = tx_dat_q;
    ovr_d       = ovr_q | (bus.fgo_clr & ~fgo_q);
    case (out_state_q)
      OUT_IDLE: begin
        if (bus.fgo_clr) begin
          fgo_d       = 1'b0;
          out_state_d = OUT_CAPT;
        end
      end
      OUT_CAPT: begin
        tx_dat_d    = bus.outr_data;
        tx_vld_d    = 1'b1;
        out_state_d = OUT_SEND;
      end
      OUT_SEND: begin
        if (bus.tx_ready) begin
          tx_vld_d    = 1'b0;
          fgo_d       = 1'b1;
          out_state_d = OUT_IDLE;
        end
      end
      default: begin
        out_state_d = OUT_IDLE;
      end
    endcase
  end

  // Interrupt follows the flags' next values so it lines up with the flag registers.
  always_comb begin
    irq_d = bus.ien & (fgi_d | fgo_d);
  end

  // State and flag registers; FGO resets high so the CPU may output immediately.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      in_state_q  <= IN_IDLE;
      fgi_q       <= 1'b0;
      inpr_q      <= '0;
      out_state_q <= OUT_IDLE;
      fgo_q       <= 1'b1;
      tx_vld_q    <= 1'b0;
      tx_dat_q    <= '0;
      ovr_q       <= 1'b0;
      irq_q       <= 1'b0;
    end else begin
      in_state_q  <= in_state_d;
      fgi_q       <= fgi_d;
      inpr_q      <= inpr_d;
      out_state_q <= out_state_d;
      fgo_q       <= fgo_d;
      tx_vld_q    <= tx_vld_d;
      tx_dat_q    <= tx_dat_d;
      ovr_q       <= ovr_d;
      irq_q       <= irq_d;
    end
  end

endmodule

// File: tb/tb_io_terminal.sv
// Testbench for io_terminal: scoreboard queues for input and output characters, one task per scenario.
// Latency: n/a.
// Backpressure: exercises a full input buffer and a stalled output sink.
module tb_io_terminal;
  import io_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b0;

  io_terminal_if bus();

  io_terminal #(.FIFO_DEPTH(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int tx_seen = 0;
  logic [DATA_W-1:0] rx_q[$];
  logic [DATA_W-1:0] tx_q[$];
  logic [DATA_W-1:0] exp_tx;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Output scoreboard: a handshake seen mid-cycle completes on the next rising edge.
  always @(negedge clk) begin
    if (reset && bus.tx_valid && bus.tx_ready) begin
      tx_seen++;
      n_cmp++;
      if (tx_q.size() == 0) begin
        n_err++;
        $display("FAIL tx_unexpected: got %h, nothing pending", bus.tx_data);
      end else begin
        exp_tx = tx_q.pop_front();
        if (bus.tx_data !== exp_tx) begin
          n_err++;
          $display("FAIL tx_data: got %h want %h", bus.tx_data, exp_tx);
        end
      end
    end
  end

  task automatic test_reset();
    repeat (2) step();
    reset = 1'b1;
    step();
    // put traffic in flight on both paths
    bus.rx_valid = 1'b1; bus.rx_data = 8'h77; step();
    bus.rx_data = 8'h78; step();
    bus.rx_valid = 1'b0;
    bus.outr_data = 8'h33; bus.fgo_clr = 1'b1; step();
    bus.fgo_clr = 1'b0; step();
    reset = 1'b0;
    #3;
    reset = 1'b1;
    rx_q.delete();
    tx_q.delete();
    #1;
    n_cmp++; if (bus.fgi !== 1'b0) begin n_err++; $display("FAIL reset_fgi: got %b want 0", bus.fgi); end
    n_cmp++; if (bus.fgo !== 1'b1) begin n_err++; $display("FAIL reset_fgo: got %b want 1", bus.fgo); end
    n_cmp++; if (bus.rx_ready !== 1'b1) begin n_err++; $display("FAIL reset_rx_ready: got %b want 1", bus.rx_ready); end
    n_cmp++; if (bus.tx_valid !== 1'b0) begin n_err++; $display("FAIL reset_tx_valid: got %b want 0", bus.tx_valid); end
    n_cmp++; if (bus.tx_data !== 8'h00) begin n_err++; $display("FAIL reset_tx_data: got %h want 00", bus.tx_data); end
    n_cmp++; if (bus.inpr_data !== 8'h00) begin n_err++; $display("FAIL reset_inpr: got %h want 00", bus.inpr_data); end
    n_cmp++; if (bus.irq !== 1'b0) begin n_err++; $display("FAIL reset_irq: got %b want 0", bus.irq); end
    n_cmp++; if (bus.out_overrun !== 1'b0) begin n_err++; $display("FAIL reset_overrun: got %b want 0", bus.out_overrun); end
    repeat (4) step();
    n_cmp++; if (bus.fgi !== 1'b0) begin n_err++; $display("FAIL reset_discard_fifo: fgi got %b want 0", bus.fgi); end
    n_cmp++; if (bus.tx_valid !== 1'b0) begin n_err++; $display("FAIL reset_discard_tx: tx_valid got %b want 0", bus.tx_valid); end
  endtask

  task automatic test_single();
    logic [DATA_W-1:0] e;
    bus.rx_data = 8'h41;
    bus.rx_valid = 1'b1;
    if (bus.rx_ready) rx_q.push_back(bus.rx_data);
    step();
    bus.rx_valid = 1'b0;
    n_cmp++; if (bus.fgi !== 1'b0) begin n_err++; $display("FAIL single_fgi_edge1: got %b want 0", bus.fgi); end
    step();
    n_cmp++; if (bus.fgi !== 1'b1) begin n_err++; $display("FAIL single_fgi_edge2: got %b want 1", bus.fgi); end
    e = rx_q.pop_front();
    n_cmp++; if (bus.inpr_data !== e) begin n_err++; $display("FAIL single_inpr: got %h want %h", bus.inpr_data, e); end
    bus.fgi_clr = 1'b1; step(); bus.fgi_clr = 1'b0;
    n_cmp++; if (bus.fgi !== 1'b0) begin n_err++; $display("FAIL single_fgi_clr: got %b want 0", bus.fgi); end
    repeat (3) step();
    n_cmp++; if (bus.fgi !== 1'b0) begin n_err++; $display("FAIL single_fgi_stays: got %b want 0", bus.fgi); end
  endtask

  task automatic test_fill();
    logic [DATA_W-1:0] e;
    logic got;
    for (int i = 0; i < 5; i++) begin
      bus.rx_data = DATA_W'(16 + i);
      bus.rx_valid = 1'b1;
      if (bus.rx_ready) rx_q.push_back(bus.rx_data);
      step();
    end
    // sixth offer against a full buffer must not be taken
    bus.rx_data = 8'h15;
    n_cmp++; if (bus.rx_ready !== 1'b0) begin n_err++; $display("FAIL fill_rx_ready: got %b want 0", bus.rx_ready); end
    if (bus.rx_ready) rx_q.push_back(bus.rx_data);
    step();
    bus.rx_valid = 1'b0;
    n_cmp++; if (bus.fgi !== 1'b1) begin n_err++; $display("FAIL fill_fgi: got %b want 1", bus.fgi); end
    e = rx_q.pop_front();
    n_cmp++; if (bus.inpr_data !== e) begin n_err++; $display("FAIL fill_inpr_first: got %h want %h", bus.inpr_data, e); end
    for (int k = 0; k < 4; k++) begin
      bus.fgi_clr = 1'b1; step(); bus.fgi_clr = 1'b0;
      n_cmp++; if (bus.fgi !== 1'b0) begin n_err++; $display("FAIL fill_clr_%0d: fgi got %b want 0", k, bus.fgi); end
      got = 1'b0;
      for (int w = 0; w < 6 && !got; w++) begin
        step();
        got = bus.fgi;
      end
      n_cmp++;
      if (!got) begin
        n_err++; $display("FAIL fill_wait_%0d: fgi got 0 want 1 within 6 cycles", k);
      end else begin
        e = rx_q.pop_front();
        if (bus.inpr_data !== e) begin n_err++; $display("FAIL fill_inpr_%0d: got %h want %h", k, bus.inpr_data, e); end
      end
    end
    bus.fgi_clr = 1'b1; step(); bus.fgi_clr = 1'b0;
    repeat (3) step();
    n_cmp++; if (bus.fgi !== 1'b0) begin n_err++; $display("FAIL fill_no_extra: fgi got %b want 0", bus.fgi); end
  endtask

  task automatic test_output();
    bus.tx_ready = 1'b0;
    bus.outr_data = 8'h5A;
    bus.fgo_clr = 1'b1;
    tx_q.push_back(8'h5A);
    step();
    bus.fgo_clr = 1'b0;
    n_cmp++; if (bus.fgo !== 1'b0) begin n_err++; $display("FAIL out_fgo_low: got %b want 0", bus.fgo); end
    step();
    n_cmp++; if (bus.tx_valid !== 1'b1) begin n_err++; $display("FAIL out_tx_valid: got %b want 1", bus.tx_valid); end
    n_cmp++; if (bus.tx_data !== 8'h5A) begin n_err++; $display("FAIL out_tx_data: got %h want 5a", bus.tx_data); end
    // CPU violates the protocol: a second OUT while the first is still pending
    bus.outr_data = 8'hA5;
    bus.fgo_clr = 1'b1; step(); bus.fgo_clr = 1'b0;
    n_cmp++; if (bus.out_overrun !== 1'b1) begin n_err++; $display("FAIL out_overrun: got %b want 1", bus.out_overrun); end
    repeat (4) step();
    n_cmp++; if (bus.tx_valid !== 1'b1) begin n_err++; $display("FAIL out_hold_valid: got %b want 1", bus.tx_valid); end
    n_cmp++; if (bus.tx_data !== 8'h5A) begin n_err++; $display("FAIL out_hold_data: got %h want 5a", bus.tx_data); end
    n_cmp++; if (bus.fgo !== 1'b0) begin n_err++; $display("FAIL out_hold_fgo: got %b want 0", bus.fgo); end
    bus.tx_ready = 1'b1;
    step();
    n_cmp++; if (bus.fgo !== 1'b1) begin n_err++; $display("FAIL out_fgo_rearm: got %b want 1", bus.fgo); end
    n_cmp++; if (bus.tx_valid !== 1'b0) begin n_err++; $display("FAIL out_tx_drop: got %b want 0", bus.tx_valid); end
    repeat (3) step();
    n_cmp++; if (tx_seen !== 1) begin n_err++; $display("FAIL out_transfer_count: got %0d want 1", tx_seen); end
    n_cmp++; if (bus.out_overrun !== 1'b1) begin n_err++; $display("FAIL out_overrun_sticky: got %b want 1", bus.out_overrun); end
  endtask

  task automatic test_irq();
    logic [DATA_W-1:0] e;
    logic got;
    n_cmp++; if (bus.irq !== 1'b0) begin n_err++; $display("FAIL irq_ien0: got %b want 0", bus.irq); end
    bus.ien = 1'b1;
    step();
    n_cmp++; if (bus.irq !== 1'b1) begin n_err++; $display("FAIL irq_fgo: got %b want 1", bus.irq); end
    bus.rx_data = 8'h66; bus.rx_valid = 1'b1;
    if (bus.rx_ready) rx_q.push_back(bus.rx_data);
    step();
    bus.rx_valid = 1'b0;
    step();
    e = rx_q.pop_front();
    n_cmp++; if (bus.inpr_data !== e || bus.fgi !== 1'b1) begin n_err++; $display("FAIL irq_inpr: got %h/%b want %h/1", bus.inpr_data, bus.fgi, e); end
    // INP and OUT on the same edge, nothing left to read
    bus.tx_ready = 1'b0;
    bus.outr_data = 8'h3C;
    bus.fgi_clr = 1'b1; bus.fgo_clr = 1'b1;
    tx_q.push_back(8'h3C);
    step();
    bus.fgi_clr = 1'b0; bus.fgo_clr = 1'b0;
    n_cmp++; if (bus.fgi !== 1'b0) begin n_err++; $display("FAIL irq_both_fgi: got %b want 0", bus.fgi); end
    n_cmp++; if (bus.fgo !== 1'b0) begin n_err++; $display("FAIL irq_both_fgo: got %b want 0", bus.fgo); end
    n_cmp++; if (bus.irq !== 1'b0) begin n_err++; $display("FAIL irq_both_low: got %b want 0", bus.irq); end
    step();
    bus.tx_ready = 1'b1;
    got = bus.fgo;
    for (int w = 0; w < 8 && !got; w++) begin
      step();
      got = bus.fgo;
    end
    n_cmp++; if (!got) begin n_err++; $display("FAIL irq_fgo_return: fgo got 0 want 1 within 8 cycles"); end
    n_cmp++; if (bus.irq !== 1'b1) begin n_err++; $display("FAIL irq_rearm: got %b want 1", bus.irq); end
    n_cmp++; if (tx_seen !== 2) begin n_err++; $display("FAIL irq_tx_count: got %0d want 2", tx_seen); end
    bus.ien = 1'b0;
    step();
    n_cmp++; if (bus.irq !== 1'b0) begin n_err++; $display("FAIL irq_ien_off: got %b want 0", bus.irq); end
  endtask

  task automatic test_back_to_back();
    logic [DATA_W-1:0] e;
    for (int c = 0; c < 70; c++) begin
      bus.rx_valid = (c < 40) ? 1'($urandom_range(0, 1)) : 1'b0;
      bus.rx_data  = DATA_W'($urandom_range(0, 255));
      if (bus.rx_valid && bus.rx_ready) rx_q.push_back(bus.rx_data);
      bus.fgi_clr = 1'b0;
      if (bus.fgi) begin
        n_cmp++;
        if (rx_q.size() == 0) begin
          n_err++; $display("FAIL b2b_extra: inpr %h with nothing pending", bus.inpr_data);
        end else begin
          e = rx_q.pop_front();
          if (bus.inpr_data !== e) begin n_err++; $display("FAIL b2b_inpr: got %h want %h", bus.inpr_data, e); end
        end
        bus.fgi_clr = 1'b1;
      end
      step();
    end
    bus.rx_valid = 1'b0;
    bus.fgi_clr = 1'b0;
    n_cmp++; if (rx_q.size() != 0) begin n_err++; $display("FAIL b2b_lost: got %0d undelivered want 0", rx_q.size()); end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation got stuck, want completion");
    $fatal(1);
  end

  initial begin
    bus.rx_valid  = 1'b0;
    bus.rx_data   = '0;
    bus.fgi_clr   = 1'b0;
    bus.outr_data = '0;
    bus.fgo_clr   = 1'b0;
    bus.tx_ready  = 1'b0;
    bus.ien       = 1'b0;
    test_reset();
    test_single();
    test_fill();
    test_output();
    test_irq();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
